// File: rtl/io_uart_tx.sv
// io_uart_tx: byte FIFO feeding an 8N1 serializer. Bytes arrive as single-cycle
// write strobes from the CPU store path, and the transmit line idles high.
module io_uart_tx #(
    parameter int BAUD_DIV = 434,
    parameter int FIFO_AW  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_io_char,
    input  logic       uart_io_we,
    output logic       uart_io_full,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_fifo_overrun
);

    localparam int                 DEPTH    = 1 << FIFO_AW;
    localparam logic [15:0]        BAUD_LD  = 16'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
    localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               ovr_q, ovr_d;

    state_t             state_q, state_d;
    logic [15:0]        baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         sh_q, sh_d;
    logic               tx_q, tx_d;

    logic               wr_en, pop, expire;

    // The full flag comes straight from the count register, so a write that
    // coincides with a pop while full is still dropped.
    assign uart_io_full    = (cnt_q == CNT_FULL);
    assign wr_en           = uart_io_we && !uart_io_full;
    assign expire          = (baud_q == 16'd0);
    assign tx              = tx_q;
    assign tx_busy         = (state_q != IDLE) || (cnt_q != '0);
    assign tx_fifo_overrun = ovr_q;

    // FIFO pointer, occupancy and sticky-overrun next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovr_d    = ovr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (wr_en && !pop)      cnt_d = cnt_q + CNT_ONE;
        else if (!wr_en && pop) cnt_d = cnt_q - CNT_ONE;
        if (uart_io_we && uart_io_full) ovr_d = 1'b1;
    end

    // FIFO storage; contents need no reset because the count gates every read
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= uart_io_char;
    end

    // Serializer next state; tx_d is the line value for the coming cycle so tx stays registered
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    sh_d    = mem_q[rd_ptr_q];
                    bit_d   = 3'd0;
                    baud_d  = BAUD_LD;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (expire) begin
                    baud_d  = BAUD_LD;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = sh_q[0];
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA: begin
                if (expire) begin
                    baud_d = BAUD_LD;
                    sh_d   = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = sh_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            STOP: begin
                if (expire) begin
                    baud_d  = BAUD_LD;
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any frame and discards queued bytes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: directed scenarios against a frame-schedule model of the UART,
// plus a line decoder and literal spot checks that pin the model.
module tb_io_uart_tx;

    localparam int B     = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] uart_io_char;
    logic       uart_io_we;
    logic       uart_io_full, tx, tx_busy, tx_fifo_overrun;

    io_uart_tx #(.BAUD_DIV(B), .FIFO_AW(AW)) dut (
        .clk(clk), .rst(rst), .uart_io_char(uart_io_char), .uart_io_we(uart_io_we),
        .uart_io_full(uart_io_full), .tx(tx), .tx_busy(tx_busy),
        .tx_fifo_overrun(tx_fifo_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: queued bytes, edge of the last pop, byte on the wire, sticky overrun
    logic [7:0] q[$];
    logic [7:0] cur = 8'h00;
    int         cyc = 0;
    int         pop_e = -1000;
    logic       m_ovr = 1'b0;
    bit         run = 1'b0;
    int         rst_cnt = 0;
    logic [7:0] rxq[$];
    logic [7:0] exp_rx[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // one clock edge of the model, using the inputs seen before the edge
    task automatic model_edge(input logic we, input logic [7:0] d);
        bit idle, acc;
        cyc++;
        idle = (cyc >= pop_e + 10*B + 1);
        acc  = we && (q.size() < DEPTH);
        if (we && !acc) m_ovr = 1'b1;
        if (idle && q.size() != 0) begin
            cur   = q.pop_front();
            pop_e = cyc;
        end
        if (acc) q.push_back(d);
    endtask

    function automatic logic exp_tx();
        int k, idx;
        k = cyc - pop_e;
        if (k < 0 || k >= 10*B) return 1'b1;
        idx = k / B;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return cur[idx-1];
    endfunction

    function automatic logic exp_busy();
        int k;
        k = cyc - pop_e;
        return (k >= 0 && k < 10*B) || (q.size() != 0);
    endfunction

    // compare DUT against the model every cycle
    initial forever begin
        @(negedge clk);
        if (run && !rst) begin
            chk("tx", 32'(tx), 32'(exp_tx()));
            chk("full", 32'(uart_io_full), 32'(q.size() == DEPTH));
            chk("busy", 32'(tx_busy), 32'(exp_busy()));
            chk("overrun", 32'(tx_fifo_overrun), 32'(m_ovr));
        end
    end

    // line decoder: mid-bit sampling, frames cut by reset are discarded
    initial forever begin
        @(negedge clk);
        if (run && !rst && tx === 1'b0) begin
            int         my_rc, idx;
            logic [7:0] b;
            bit         ok;
            my_rc = rst_cnt;
            ok    = 1'b1;
            b     = 8'h00;
            for (int i = 1; i <= 9*B + B/2; i++) begin
                @(negedge clk);
                if (rst_cnt != my_rc) begin
                    ok = 1'b0;
                    break;
                end
                if (i >= B + B/2 && ((i - B - B/2) % B) == 0) begin
                    idx = (i - B - B/2) / B;
                    if (idx < 8) b[idx] = tx;
                    else if (tx !== 1'b1) ok = 1'b0;
                end
            end
            if (ok) rxq.push_back(b);
        end
    end

    task automatic cycle(input logic we, input logic [7:0] d);
        uart_io_we   = we;
        uart_io_char = d;
        @(posedge clk);
        model_edge(we, d);
        @(negedge clk);
        uart_io_we = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((q.size() != 0 || (cyc - pop_e) < 10*B) && g < 3000) begin
            cycle(1'b0, 8'h00);
            g++;
        end
        chk("drain_bound", 32'(g >= 3000), 32'd0);
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
    endtask

    task automatic check_rx();
        chk("rx_count", 32'(rxq.size()), 32'(exp_rx.size()));
        for (int i = 0; i < rxq.size() && i < exp_rx.size(); i++)
            chk("rx_byte", 32'(rxq[i]), 32'(exp_rx[i]));
        rxq.delete();
        exp_rx.delete();
    endtask

    // asynchronous reset pulse between edges; called at a falling edge
    task automatic do_reset();
        #2;
        rst = 1'b1;
        rst_cnt++;
        q.delete();
        m_ovr = 1'b0;
        pop_e = -1000;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_full", 32'(uart_io_full), 32'd0);
        chk("rst_ovr", 32'(tx_fifo_overrun), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        rxq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1'b1;
        uart_io_we = 1'b0;
        uart_io_char = 8'h00;
        #2;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_full", 32'(uart_io_full), 32'd0);
        chk("reset_busy", 32'(tx_busy), 32'd0);
        chk("reset_ovr", 32'(tx_fifo_overrun), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        run = 1'b1;
        cycle(1'b0, 8'h00);

        // 1: single byte 0x55
        cycle(1'b1, 8'h55);
        for (int k = 1; k <= 42; k++) begin
            cycle(1'b0, 8'h00);
            case (k)
                1:  chk("t1_start_first", 32'(tx), 32'd0);
                4:  chk("t1_start_last", 32'(tx), 32'd0);
                5:  chk("t1_bit0", 32'(tx), 32'd1);
                9:  chk("t1_bit1", 32'(tx), 32'd0);
                36: chk("t1_bit7", 32'(tx), 32'd0);
                37: chk("t1_stop", 32'(tx), 32'd1);
                40: chk("t1_busy_hold", 32'(tx_busy), 32'd1);
                41: chk("t1_busy_fall", 32'(tx_busy), 32'd0);
                default: ;
            endcase
        end
        drain();
        exp_rx.push_back(8'h55);
        check_rx();

        // 2: back-to-back 0xA3, 0x0F
        cycle(1'b1, 8'hA3);
        cycle(1'b1, 8'h0F);
        chk("t2_start1", 32'(tx), 32'd0);
        for (int k = 2; k <= 45; k++) begin
            cycle(1'b0, 8'h00);
            if (k == 41) chk("t2_idle_gap", 32'(tx), 32'd1);
            if (k == 42) chk("t2_start2", 32'(tx), 32'd0);
        end
        drain();
        exp_rx.push_back(8'hA3);
        exp_rx.push_back(8'h0F);
        check_rx();

        // 3: fill and overrun
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, 8'(i));
            if (i == 5) begin
                chk("t3_full", 32'(uart_io_full), 32'd1);
                chk("t3_no_ovr_yet", 32'(tx_fifo_overrun), 32'd0);
            end
            if (i == 6) chk("t3_ovr", 32'(tx_fifo_overrun), 32'd1);
        end
        drain();
        for (int i = 1; i <= 5; i++) exp_rx.push_back(8'(i));
        check_rx();
        chk("t3_ovr_sticky", 32'(tx_fifo_overrun), 32'd1);
        do_reset();
        cycle(1'b0, 8'h00);

        // 4: write while full on the popping edge
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h11 + i));
        chk("t4_full", 32'(uart_io_full), 32'd1);
        chk("t4_no_ovr", 32'(tx_fifo_overrun), 32'd0);
        while (cyc + 1 < pop_e + 10*B + 1) cycle(1'b0, 8'h00);
        chk("t4_full_before_pop", 32'(uart_io_full), 32'd1);
        cycle(1'b1, 8'h99);
        chk("t4_ovr", 32'(tx_fifo_overrun), 32'd1);
        chk("t4_full_clear", 32'(uart_io_full), 32'd0);
        drain();
        for (int i = 0; i < 5; i++) exp_rx.push_back(8'(8'h11 + i));
        check_rx();

        // 5: reset during data bit 3 of 0xC3
        do_reset();
        cycle(1'b0, 8'h00);
        cycle(1'b1, 8'hC3);
        w = cyc;
        while (cyc < w + 18) cycle(1'b0, 8'h00);
        chk("t5_bit3_low", 32'(tx), 32'd0);
        do_reset();
        cycle(1'b1, 8'h7E);
        drain();
        exp_rx.push_back(8'h7E);
        check_rx();

        // 6: 20 bytes paced on full, pointers wrap several times
        begin
            int i = 0;
            int g = 0;
            while (i < 20 && g < 5000) begin
                if (!uart_io_full) begin
                    cycle(1'b1, 8'(i));
                    i++;
                end else begin
                    cycle(1'b0, 8'h00);
                end
                g++;
            end
            chk("t6_stream_bound", 32'(i), 32'd20);
        end
        drain();
        for (int i = 0; i < 20; i++) exp_rx.push_back(8'(i));
        check_rx();
        chk("t6_no_ovr", 32'(tx_fifo_overrun), 32'd0);

        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
